// File: rtl/fp_mul_scheduler.sv
// Purpose: round-robin arbiter sharing one multi-cycle FP multiplier between requesters A and B.
// Latency: legal rounding mode LAT+1 cycles from ready to response, illegal mode 1 cycle.
// Backpressure: one op outstanding; both readies stay low until the response is taken with r_ready.
module fp_mul_scheduler #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_x,
    input  logic [31:0] a_y,
    input  logic [2:0]  a_rm,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_x,
    input  logic [31:0] b_y,
    input  logic [2:0]  b_rm,
    output logic [31:0] m_x,
    output logic [31:0] m_y,
    output logic [2:0]  m_rm,
    input  logic [31:0] m_z,
    input  logic        m_ovrf,
    input  logic        m_udrf,
    output logic        r_valid,
    input  logic        r_ready,
    output logic        r_id,
    output logic [31:0] r_z,
    output logic        r_ovrf,
    output logic        r_udrf,
    output logic        r_inv
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [2:0]  RM_MAX   = 3'd4;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_b_q, last_b_d;   // 1 = B was served last, so A wins the next tie
    logic [31:0] m_x_q, m_x_d;
    logic [31:0] m_y_q, m_y_d;
    logic [2:0]  m_rm_q, m_rm_d;
    logic        id_q, id_d;
    logic [31:0] r_z_q, r_z_d;
    logic        r_ovrf_q, r_ovrf_d;
    logic        r_udrf_q, r_udrf_d;
    logic        r_inv_q, r_inv_d;

    logic        grant_a;
    logic        grant_b;
    logic        in_idle;
    logic        accept;
    logic [2:0]  sel_rm;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_a = a_valid && (!b_valid || last_b_q);
        grant_b = b_valid && !grant_a;
        in_idle = (state_q == IDLE) && !rst;   // keeps readies low while reset is held
        accept  = in_idle && (grant_a || grant_b);
        sel_rm  = grant_b ? b_rm : a_rm;
    end

    assign a_ready = in_idle && grant_a;
    assign b_ready = in_idle && grant_b;

    // Next-state and datapath: latch operands on accept, count out the settle time, hold the response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        m_x_d    = m_x_q;
        m_y_d    = m_y_q;
        m_rm_d   = m_rm_q;
        id_d     = id_q;
        r_z_d    = r_z_q;
        r_ovrf_d = r_ovrf_q;
        r_udrf_d = r_udrf_q;
        r_inv_d  = r_inv_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    m_x_d    = grant_b ? b_x : a_x;
                    m_y_d    = grant_b ? b_y : a_y;
                    m_rm_d   = sel_rm;
                    id_d     = grant_b;
                    last_b_d = grant_b;
                    if (sel_rm <= RM_MAX) begin
                        state_d = CALC;
                        cnt_d   = CNT_INIT;
                    end else begin
                        // Illegal mode never touches the multiplier: answer with a quiet NaN.
                        state_d  = DONE;
                        r_z_d    = QNAN;
                        r_inv_d  = 1'b1;
                        r_ovrf_d = 1'b0;
                        r_udrf_d = 1'b0;
                    end
                end
            end
            CALC: begin
                if (cnt_q == 4'd0) begin
                    state_d  = DONE;
                    r_z_d    = m_z;
                    r_ovrf_d = m_ovrf;
                    r_udrf_d = m_udrf;
                    r_inv_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (r_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight and clears every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            last_b_q <= 1'b1;
            m_x_q    <= 32'd0;
            m_y_q    <= 32'd0;
            m_rm_q   <= 3'd0;
            id_q     <= 1'b0;
            r_z_q    <= 32'd0;
            r_ovrf_q <= 1'b0;
            r_udrf_q <= 1'b0;
            r_inv_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            m_x_q    <= m_x_d;
            m_y_q    <= m_y_d;
            m_rm_q   <= m_rm_d;
            id_q     <= id_d;
            r_z_q    <= r_z_d;
            r_ovrf_q <= r_ovrf_d;
            r_udrf_q <= r_udrf_d;
            r_inv_q  <= r_inv_d;
        end
    end

    assign m_x     = m_x_q;
    assign m_y     = m_y_q;
    assign m_rm    = m_rm_q;
    assign r_valid = (state_q == DONE);
    assign r_id    = id_q;
    assign r_z     = r_z_q;
    assign r_ovrf  = r_ovrf_q;
    assign r_udrf  = r_udrf_q;
    assign r_inv   = r_inv_q;

endmodule
